// File: rtl/axi_ar_slave_arbiter_if.sv
// AR-side bundle between one slave port's arbiter and the master AR FIFO heads / slave AR channel.
// The slave modport is the arbiter's view; master is the environment driving FIFO heads and the slave.
interface axi_ar_slave_arbiter_if #(
  parameter int unsigned M_CNT  = 4,
  parameter int unsigned DATA_W = 49
);
  logic [M_CNT-1:0]        m_ar_valid;
  logic [M_CNT*DATA_W-1:0] m_ar_data;
  logic [M_CNT-1:0]        m_ar_pop;
  logic [7:0]              s_arid;
  logic [31:0]             s_araddr;
  logic [3:0]              s_arlen;
  logic [2:0]              s_arsize;
  logic [1:0]              s_arburst;
  logic                    s_arvalid;
  logic                    s_arready;
  logic                    s_r_done;
  logic [3:0]              outst_cnt;

  modport slave (
    input  m_ar_valid, m_ar_data, s_arready, s_r_done,
    output m_ar_pop, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, outst_cnt
  );

  modport master (
    output m_ar_valid, m_ar_data, s_arready, s_r_done,
    input  m_ar_pop, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, outst_cnt
  );
endinterface

// File: rtl/axi_ar_slave_arbiter.sv
// Per-slave round-robin AR arbiter with outstanding-burst limit.
// Optional AR_BACK2BACK_EN: re-arbitrate on the accepting cycle for one AR per cycle.
module axi_ar_slave_arbiter #(
  parameter int unsigned M_CNT     = 4,
  parameter int unsigned DATA_W    = 49,
  parameter int unsigned MAX_OUTST = 4
) (
  input logic                   axi_clk,
  input logic                   axi_rst_n,
  axi_ar_slave_arbiter_if.slave bus
);
  localparam int unsigned PtrW = (M_CNT > 1) ? $clog2(M_CNT) : 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]   winner_q, winner_d;
  logic [PtrW-1:0]   rr_next;
  logic [3:0]        count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [M_CNT-1:0]  req, pop;
  logic [PtrW:0]     pick;
  logic              grant, accept, done;

  // Returns {found, index} of the first set request at or above ptr, wrapping at M_CNT-1.
  function automatic logic [PtrW:0] rr_pick(input logic [M_CNT-1:0] r, input logic [PtrW-1:0] p);
    logic [PtrW:0]   res;
    logic [PtrW-1:0] sel;
    int unsigned     idx;
    res = '0;
    for (int unsigned i = 0; i < M_CNT; i++) begin
      idx = (32'(p) + i) % M_CNT;
      sel = PtrW'(idx);
      if (!res[PtrW] && r[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  assign accept  = (state_q == StSend) && bus.s_arready;
  assign done    = bus.s_r_done;
  assign rr_next = (winner_q == PtrW'(M_CNT - 1)) ? '0 : winner_q + 1'b1;

  // A done pulse with nothing outstanding is spurious and must not wrap the counter.
  always_comb begin
    count_d = count_q;
    if (accept && !done) begin
      count_d = count_q + 4'd1;
    end else if (!accept && done && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    winner_d = winner_q;
    data_d   = data_q;
    req      = '0;
    pick     = '0;
    grant    = 1'b0;
    pop      = '0;
    case (state_q)
      StIdle: begin
        req   = bus.m_ar_valid & {M_CNT{count_q < 4'(MAX_OUTST)}};
        pick  = rr_pick(req, rr_ptr_q);
        grant = pick[PtrW];
      end
      StSend: begin
        if (accept) begin
          rr_ptr_d = rr_next;
          state_d  = StIdle;
`ifdef AR_BACK2BACK_EN
          req   = bus.m_ar_valid & {M_CNT{count_d < 4'(MAX_OUTST)}};
          pick  = rr_pick(req, rr_next);
          grant = pick[PtrW];
`endif
        end
      end
      default: state_d = StIdle;
    endcase
    if (grant) begin
      pop[pick[PtrW-1:0]] = 1'b1;
      winner_d = pick[PtrW-1:0];
      data_d   = bus.m_ar_data[32'(pick[PtrW-1:0]) * DATA_W +: DATA_W];
      state_d  = StSend;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      winner_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      winner_q <= winner_d;
      count_q  <= count_d;
      data_q   <= data_d;
    end
  end

  // Pop is combinational, so it is masked while reset is held.
  assign bus.m_ar_pop  = pop & {M_CNT{axi_rst_n}};
  assign bus.s_arvalid = (state_q == StSend);
  // The id field already carries the master number in its upper nibble from upstream.
  assign bus.s_arid    = data_q[48:41];
  assign bus.s_araddr  = data_q[40:9];
  assign bus.s_arlen   = data_q[8:5];
  assign bus.s_arsize  = data_q[4:2];
  assign bus.s_arburst = data_q[1:0];
  assign bus.outst_cnt = count_q;
endmodule

// File: tb/tb_axi_ar_slave_arbiter.sv
// Directed vector-table bench for axi_ar_slave_arbiter plus short hand-written sequences.
module tb_axi_ar_slave_arbiter;
  localparam int unsigned M_CNT  = 4;
  localparam int unsigned DATA_W = 49;

  typedef struct {
    bit         rst_n;
    logic [3:0] valid;
    bit         rdy;
    bit         done;
    int         pop;
    int         vld;
    int         cnt;
    int         m;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  axi_ar_slave_arbiter_if #(.M_CNT(M_CNT), .DATA_W(DATA_W)) bus ();

  axi_ar_slave_arbiter #(.M_CNT(M_CNT), .DATA_W(DATA_W), .MAX_OUTST(4)) dut (
    .axi_clk  (clk),
    .axi_rst_n(rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] mk_word(input int m);
    logic [7:0]  id;
    logic [31:0] addr;
    id   = 8'(m * 16 + 3);
    addr = 32'h1000_0000 | 32'(m << 5);
    return {id, addr, 4'(m + 1), 3'(m), 2'b01};
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_beat(input int idx, input int m);
    chk("arid", idx, 64'(bus.s_arid), 64'(m * 16 + 3));
    chk("araddr", idx, 64'(bus.s_araddr), 64'(32'h1000_0000 + m * 32));
    chk("arlen", idx, 64'(bus.s_arlen), 64'(m + 1));
    chk("arsize", idx, 64'(bus.s_arsize), 64'(m));
    chk("arburst", idx, 64'(bus.s_arburst), 64'd1);
  endtask

  task automatic add(input bit r, input logic [3:0] v, input bit rdy, input bit dn,
                     input int pop, input int vld, input int cnt, input int m);
    vec_t x;
    x.rst_n = r; x.valid = v; x.rdy = rdy; x.done = dn;
    x.pop = pop; x.vld = vld; x.cnt = cnt; x.m = m;
    vecs.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.m_ar_valid = '0; bus.s_arready = 1'b0; bus.s_r_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.m_ar_valid = '0;
    bus.s_arready  = 1'b0;
    bus.s_r_done   = 1'b0;
    for (int m = 0; m < int'(M_CNT); m++) bus.m_ar_data[m*DATA_W +: DATA_W] = mk_word(m);

    // Reset with every master requesting.
    add(0, 4'hF, 0, 0, 0, -1, -1, -1);
    add(0, 4'hF, 0, 0, 0,  0,  0, -1);
`ifndef AR_BACK2BACK_EN
    // Single beat from master 2, valid dropped during SEND.
    add(1, 4'b0100, 0, 0, 4, 0, 0, -1);
    add(1, 4'b0000, 0, 0, 0, 1, 0,  2);
    add(1, 4'b0000, 1, 0, 0, 1, 0,  2);
    add(1, 4'b0000, 0, 1, 0, 0, 1, -1);
    add(1, 4'b0000, 0, 0, 0, 0, 0, -1);
    // Done with nothing outstanding is ignored.
    add(1, 4'b0000, 0, 1, 0, 0, 0, -1);
    add(1, 4'b0000, 0, 0, 0, 0, 0, -1);
    // Round robin 0,1,2,3,0 with a done after each accept.
    add(0, 4'hF, 0, 0, 0, -1, -1, -1);
    add(0, 4'hF, 0, 0, 0,  0,  0, -1);
    add(1, 4'hF, 1, 0, 1, 0, 0, -1);
    add(1, 4'hF, 1, 0, 0, 1, 0,  0);
    add(1, 4'hF, 1, 1, 2, 0, 1, -1);
    add(1, 4'hF, 1, 0, 0, 1, 0,  1);
    add(1, 4'hF, 1, 1, 4, 0, 1, -1);
    add(1, 4'hF, 1, 0, 0, 1, 0,  2);
    add(1, 4'hF, 1, 1, 8, 0, 1, -1);
    add(1, 4'hF, 1, 0, 0, 1, 0,  3);
    add(1, 4'hF, 1, 1, 1, 0, 1, -1);
    add(1, 4'hF, 1, 0, 0, 1, 0,  0);
    // Backpressure: 5 stalled cycles, accept on the 6th.
    add(0, 4'hF, 0, 0, 0, -1, -1, -1);
    add(0, 4'hF, 0, 0, 0,  0,  0, -1);
    add(1, 4'hF, 0, 0, 1, 0, 0, -1);
    for (int k = 0; k < 5; k++) add(1, 4'h0, 0, 0, 0, 1, 0, 0);
    add(1, 4'h0, 1, 0, 0, 1, 0,  0);
    add(1, 4'h0, 0, 0, 0, 0, 1, -1);
    // Limit: climb to 4, stall, one done releases a grant.
    add(1, 4'hF, 1, 0, 2, 0, 1, -1);
    add(1, 4'hF, 1, 0, 0, 1, 1,  1);
    add(1, 4'hF, 1, 0, 4, 0, 2, -1);
    add(1, 4'hF, 1, 0, 0, 1, 2,  2);
    add(1, 4'hF, 1, 0, 8, 0, 3, -1);
    add(1, 4'hF, 1, 0, 0, 1, 3,  3);
    add(1, 4'hF, 1, 0, 0, 0, 4, -1);
    add(1, 4'hF, 1, 1, 0, 0, 4, -1);
    add(1, 4'hF, 1, 0, 1, 0, 3, -1);
    add(1, 4'hF, 1, 1, 0, 1, 3,  0);
    add(1, 4'hF, 0, 0, 2, 0, 3, -1);
    add(1, 4'hF, 0, 0, 0, 1, 3,  1);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n          = vecs[i].rst_n;
      bus.m_ar_valid = vecs[i].valid;
      bus.s_arready  = vecs[i].rdy;
      bus.s_r_done   = vecs[i].done;
      #2;
      chk("pop", i, 64'(bus.m_ar_pop), 64'(vecs[i].pop));
      if (vecs[i].vld >= 0) chk("arvalid", i, 64'(bus.s_arvalid), 64'(vecs[i].vld));
      if (vecs[i].cnt >= 0) chk("outst_cnt", i, 64'(bus.outst_cnt), 64'(vecs[i].cnt));
      if (vecs[i].m >= 0) chk_beat(i, vecs[i].m);
    end

`ifndef AR_BACK2BACK_EN
    // Bounded handshake sequence from master 3.
    begin
      bit got;
      do_reset();
      bus.m_ar_valid = 4'b1000;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        #2;
        if (bus.m_ar_pop == 4'b1000) got = 1'b1;
        @(negedge clk);
      end
      chk("pop_wait", 100, 64'(got), 64'd1);
      bus.m_ar_valid = 4'b0000;
      #2;
      chk("seq_arvalid", 101, 64'(bus.s_arvalid), 64'd1);
      chk_beat(102, 3);
      bus.s_arready = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        #2;
        if (!bus.s_arvalid) got = 1'b1;
      end
      bus.s_arready = 1'b0;
      chk("accept_wait", 103, 64'(got), 64'd1);
      chk("seq_cnt", 104, 64'(bus.outst_cnt), 64'd1);
    end
`else
    // Sustained one AR per cycle with a done every cycle.
    do_reset();
    bus.m_ar_valid = 4'hF;
    bus.s_arready  = 1'b1;
    bus.s_r_done   = 1'b1;
    #2;
    chk("b2b_pop0", 200, 64'(bus.m_ar_pop), 64'd1);
    chk("b2b_vld0", 200, 64'(bus.s_arvalid), 64'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #2;
      chk("b2b_vld", 200 + k, 64'(bus.s_arvalid), 64'd1);
      chk("b2b_pop", 200 + k, 64'(bus.m_ar_pop), 64'(1 << (k % 4)));
      chk("b2b_cnt", 200 + k, 64'(bus.outst_cnt), 64'd0);
      chk_beat(200 + k, (k - 1) % 4);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
